// File: rtl/hc595_rx_pkg.sv
// Shared types and constants for the HC595-style serial receiver.
// The frame state tracks how many shifts have landed since the last latch.
package hc595_rx_pkg;

   localparam int HC595_DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_SHIFTING = 2'd1,
      ST_FULL     = 2'd2,
      ST_OVER     = 2'd3
   } rx_state_e;

   function automatic rx_state_e state_for_count(input int unsigned count,
                                                 input int unsigned width);
      if (count == 0)          return ST_IDLE;
      else if (count < width)  return ST_SHIFTING;
      else if (count == width) return ST_FULL;
      else                     return ST_OVER;
   endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Synchronizer for one asynchronous pin plus rising-edge detect; level and rise lag the pin by STAGES clocks.
// Rise stays suppressed after reset until the synchronized pin has been seen low, so a held-high pin never fakes an edge.
module sync_edge_detect #(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clock,
   input  logic reset,
   input  logic pin_i,
   output logic level_o,
   output logic rise_o
);

   localparam int             FW        = $clog2(STAGES + 1);
   localparam logic [FW-1:0]  FILL_DONE = FW'(STAGES);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;
   logic              armed_q;
   logic [FW-1:0]     fill_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         sync_q  <= {STAGES{RESET_VAL}};
         prev_q  <= RESET_VAL;
         armed_q <= 1'b0;
         fill_q  <= '0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], pin_i};
         prev_q <= sync_q[STAGES-1];
         // Reset-loaded chain contents are not real pin samples; wait for a full flush.
         if (fill_q != FILL_DONE) begin
            fill_q <= fill_q + FW'(1);
         end else if (!sync_q[STAGES-1]) begin
            armed_q <= 1'b1;
         end
      end
   end

   assign level_o = sync_q[STAGES-1];
   assign rise_o  = armed_q & sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/hc595_receiver.sv
// 74HC595-style receiver oversampling ser/srclk/rclk/oe; shift and latch land two clocks after an edge is sampled.
// parallel_out follows storage one clock later, gated by oe; the pins cannot be backpressured.
module hc595_receiver
   import hc595_rx_pkg::*;
#(
   parameter int WIDTH       = HC595_DEFAULT_WIDTH,
   parameter int SYNC_STAGES = 2
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           ser,
   input  logic                           srclk,
   input  logic                           rclk,
   input  logic                           oe,
   output logic [WIDTH-1:0]               parallel_out,
   output logic                           cascade_out,
   output logic                           latch_valid,
   output logic                           frame_error,
   output logic [$clog2(2*WIDTH+1)-1:0]   bit_count
);

   localparam int            CW      = $clog2(2*WIDTH+1);
   localparam logic [CW-1:0] CNT_MAX = CW'(2*WIDTH);

   logic ser_lvl, srclk_lvl, rclk_lvl, oe_lvl;
   logic srclk_rise, rclk_rise;
   logic ser_rise_unused, oe_rise_unused;
   logic srclk_lvl_unused, rclk_lvl_unused;

   sync_edge_detect #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_ser (
      .clock   (clock),
      .reset   (reset),
      .pin_i   (ser),
      .level_o (ser_lvl),
      .rise_o  (ser_rise_unused)
   );

   sync_edge_detect #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_srclk (
      .clock   (clock),
      .reset   (reset),
      .pin_i   (srclk),
      .level_o (srclk_lvl),
      .rise_o  (srclk_rise)
   );

   sync_edge_detect #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_rclk (
      .clock   (clock),
      .reset   (reset),
      .pin_i   (rclk),
      .level_o (rclk_lvl),
      .rise_o  (rclk_rise)
   );

   sync_edge_detect #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_oe (
      .clock   (clock),
      .reset   (reset),
      .pin_i   (oe),
      .level_o (oe_lvl),
      .rise_o  (oe_rise_unused)
   );

   assign srclk_lvl_unused = srclk_lvl;
   assign rclk_lvl_unused  = rclk_lvl;

   logic [WIDTH-1:0] shift_q, shift_d;
   logic [WIDTH-1:0] storage_q;
   logic [WIDTH-1:0] pout_q;
   logic [CW-1:0]    count_q, count_d;
   logic             latch_valid_q;
   logic             frame_error_q;
   rx_state_e        state_q;

   always_comb begin
      shift_d = shift_q;
      if (srclk_rise) begin
         shift_d = {shift_q[WIDTH-2:0], ser_lvl};
      end
   end

   // A latch restarts the frame; a coinciding shift becomes its first bit.
   always_comb begin
      count_d = count_q;
      if (rclk_rise) begin
         count_d = srclk_rise ? CW'(1) : '0;
      end else if (srclk_rise && (count_q != CNT_MAX)) begin
         count_d = count_q + CW'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         shift_q       <= '0;
         storage_q     <= '0;
         pout_q        <= '0;
         count_q       <= '0;
         latch_valid_q <= 1'b0;
         frame_error_q <= 1'b0;
      end else begin
         shift_q       <= shift_d;
         count_q       <= count_d;
         state_q       <= state_for_count(32'(count_d), WIDTH);
         latch_valid_q <= rclk_rise;
         if (rclk_rise) begin
            storage_q     <= shift_q;
            frame_error_q <= (state_q != ST_FULL);
         end
         pout_q <= oe_lvl ? '0 : storage_q;
      end
   end

   assign parallel_out = pout_q;
   assign cascade_out  = shift_q[WIDTH-1];
   assign latch_valid  = latch_valid_q;
   assign frame_error  = frame_error_q;
   assign bit_count    = count_q;

endmodule

// File: tb/tb_hc595_receiver.sv
// Bench for hc595_receiver: table of shift/latch frames plus hand sequences for oe, coincident edges, reset and chaining.
// Latch results are checked by a scoreboard monitor that pops an expectation on every latch_valid pulse.
module tb_hc595_receiver;
   import hc595_rx_pkg::*;

   localparam int HOLD = 4;

   logic       clock = 1'b0;
   logic       reset;
   logic       ser, srclk, rclk, oe;
   logic [7:0] parallel_out, parallel_out_dn;
   logic       cascade_out, cascade_out_dn;
   logic       latch_valid, latch_valid_dn;
   logic       frame_error, frame_error_dn;
   logic [4:0] bit_count, bit_count_dn;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   hc595_receiver #(.WIDTH(8), .SYNC_STAGES(2)) dut (
      .clock(clock), .reset(reset), .ser(ser), .srclk(srclk), .rclk(rclk), .oe(oe),
      .parallel_out(parallel_out), .cascade_out(cascade_out), .latch_valid(latch_valid),
      .frame_error(frame_error), .bit_count(bit_count)
   );

   hc595_receiver #(.WIDTH(8), .SYNC_STAGES(2)) dut_dn (
      .clock(clock), .reset(reset), .ser(cascade_out), .srclk(srclk), .rclk(rclk), .oe(oe),
      .parallel_out(parallel_out_dn), .cascade_out(cascade_out_dn), .latch_valid(latch_valid_dn),
      .frame_error(frame_error_dn), .bit_count(bit_count_dn)
   );

   typedef struct packed {
      logic [7:0] pout;
      logic       ferr;
      logic [4:0] cnt;
   } exp_t;

   typedef struct {
      int          nbits;
      logic [31:0] bits;
      logic        oe_n;
      logic [7:0]  exp_pout;
      logic        exp_ferr;
      int          exp_cnt;
      rx_state_e   exp_state;
   } vec_t;

   exp_t sb_q[$];
   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic hold(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic shift_bit(input logic b);
      ser = b;
      hold(HOLD);
      srclk = 1'b1;
      hold(HOLD);
      srclk = 1'b0;
      hold(HOLD);
   endtask

   task automatic shift_bits(input int n, input logic [31:0] bits);
      for (int i = n - 1; i >= 0; i--) shift_bit(bits[i]);
   endtask

   task automatic do_latch(input exp_t e);
      sb_q.push_back(e);
      rclk = 1'b1;
      hold(HOLD);
      rclk = 1'b0;
      hold(HOLD);
   endtask

   // Scoreboard monitor, sampling on the falling edge.
   exp_t pend_exp;
   logic pout_pend = 1'b0;
   logic lv_prev   = 1'b0;

   always @(negedge clock) begin
      if (reset !== 1'b0) begin
         lv_prev   = 1'b0;
         pout_pend = 1'b0;
      end else begin
         if (pout_pend) begin
            check("latch_pout", 32'(parallel_out), 32'(pend_exp.pout));
            pout_pend = 1'b0;
         end
         if (latch_valid === 1'b1) begin
            if (lv_prev) begin
               checks++;
               errors++;
               $display("FAIL latch_valid_width: got 2+ cycles expected 1");
            end else if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_latch: got pulse expected none");
            end else begin
               pend_exp = sb_q.pop_front();
               check("latch_ferr", 32'(frame_error), 32'(pend_exp.ferr));
               check("latch_cnt", 32'(bit_count), 32'(pend_exp.cnt));
               pout_pend = 1'b1;
            end
         end
         lv_prev = (latch_valid === 1'b1);
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{8,  32'hA5,    1'b0, 8'hA5, 1'b0, 8,  ST_FULL};
      vecs[1] = '{5,  32'h13,    1'b0, 8'hB3, 1'b1, 5,  ST_SHIFTING};
      vecs[2] = '{12, 32'hC3F,   1'b0, 8'h3F, 1'b1, 12, ST_OVER};
      vecs[3] = '{8,  32'h3C,    1'b0, 8'h3C, 1'b0, 8,  ST_FULL};
      vecs[4] = '{0,  32'h0,     1'b0, 8'h3C, 1'b1, 0,  ST_IDLE};
      vecs[5] = '{20, 32'h5A5A5, 1'b0, 8'hA5, 1'b1, 16, ST_OVER};
      vecs[6] = '{8,  32'hFF,    1'b1, 8'h00, 1'b0, 8,  ST_FULL};
      vecs[7] = '{8,  32'h81,    1'b0, 8'h81, 1'b0, 8,  ST_FULL};

      reset = 1'b1;
      ser   = 1'b0;
      srclk = 1'b0;
      rclk  = 1'b0;
      oe    = 1'b0;
      hold(3);
      check("rst_pout", 32'(parallel_out), 32'h0);
      check("rst_cascade", 32'(cascade_out), 32'h0);
      check("rst_latch_valid", 32'(latch_valid), 32'h0);
      check("rst_ferr", 32'(frame_error), 32'h0);
      check("rst_cnt", 32'(bit_count), 32'h0);
      check("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
      reset = 1'b0;
      hold(8);

      for (int v = 0; v < 8; v++) begin
         oe = vecs[v].oe_n;
         shift_bits(vecs[v].nbits, vecs[v].bits);
         check($sformatf("vec%0d_cnt", v), 32'(bit_count), 32'(vecs[v].exp_cnt));
         check($sformatf("vec%0d_state", v), 32'(dut.state_q), 32'(vecs[v].exp_state));
         do_latch('{vecs[v].exp_pout, vecs[v].exp_ferr, 5'd0});
      end

      // oe gating latency: the output moves on the third edge after the pin changes.
      shift_bits(8, 32'h3C);
      do_latch('{8'h3C, 1'b0, 5'd0});
      oe = 1'b1;
      hold(2);
      check("oe_off_early", 32'(parallel_out), 32'h3C);
      hold(1);
      check("oe_off", 32'(parallel_out), 32'h00);
      oe = 1'b0;
      hold(2);
      check("oe_on_early", 32'(parallel_out), 32'h00);
      hold(1);
      check("oe_on", 32'(parallel_out), 32'h3C);

      // Eighth shift coincides with the latch: storage gets the pre-shift value.
      shift_bits(7, 32'h55);
      ser = 1'b1;
      hold(HOLD);
      sb_q.push_back('{8'h55, 1'b1, 5'd1});
      srclk = 1'b1;
      rclk  = 1'b1;
      hold(HOLD);
      srclk = 1'b0;
      rclk  = 1'b0;
      hold(HOLD);
      check("coinc_cnt", 32'(bit_count), 32'd1);
      check("coinc_cascade", 32'(cascade_out), 32'h1);
      do_latch('{8'hAB, 1'b1, 5'd0});

      // Reset mid-frame with srclk held high.
      shift_bits(3, 32'h5);
      ser = 1'b1;
      hold(HOLD);
      srclk = 1'b1;
      hold(HOLD);
      check("pre_reset_cnt", 32'(bit_count), 32'd4);
      reset = 1'b1;
      hold(2);
      reset = 1'b0;
      hold(10);
      check("mid_rst_cnt", 32'(bit_count), 32'h0);
      check("mid_rst_pout", 32'(parallel_out), 32'h0);
      check("mid_rst_cascade", 32'(cascade_out), 32'h0);
      check("mid_rst_ferr", 32'(frame_error), 32'h0);
      check("mid_rst_latch_valid", 32'(latch_valid), 32'h0);
      srclk = 1'b0;
      hold(HOLD);
      check("no_spurious_shift", 32'(bit_count), 32'h0);
      do_latch('{8'h00, 1'b1, 5'd0});

      // Two chained receivers.
      shift_bits(16, 32'h12AB);
      check("chain_cnt", 32'(bit_count), 32'd16);
      check("chain_cascade", 32'(cascade_out), 32'h1);
      do_latch('{8'hAB, 1'b1, 5'd0});
      check("chain_down_pout", 32'(parallel_out_dn), 32'h12);
      check("chain_down_ferr", 32'(frame_error_dn), 32'h1);

      hold(10);
      check("scoreboard_drain", 32'(sb_q.size()), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hc595_receiver.md
HC595_RECEIVER -- requirements
Module: hc595_receiver

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning shift/storage register width (>=2).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning synchronizer depth per input pin (>=2).
REQ-003 SHALL have port clock, input, 1, meaning the single system clock.
REQ-004 SHALL have port reset, input, 1, meaning synchronous active-high reset.
REQ-005 SHALL have port ser, input, 1, meaning asynchronous serial data pin.
REQ-006 SHALL have port srclk, input, 1, meaning asynchronous shift clock pin; a rising edge shifts the register.
REQ-007 SHALL have port rclk, input, 1, meaning asynchronous latch clock pin; a rising edge copies shift to storage.
REQ-008 SHALL have port oe, input, 1, meaning asynchronous active-low output enable pin.
REQ-009 SHALL have port parallel_out, output, WIDTH, meaning storage register, gated by oe.
REQ-010 SHALL have port cascade_out, output, 1, meaning shift register MSB (QH').
REQ-011 SHALL have port latch_valid, output, 1, meaning one-cycle pulse per accepted latch.
REQ-012 SHALL have port frame_error, output, 1, meaning the last latch saw a bit count other than WIDTH.
REQ-013 SHALL have port bit_count, output, $clog2(2*WIDTH+1), meaning shifts since the last latch, saturating.

Function
REQ-014 SHALL pass ser, srclk, rclk and oe through SYNC_STAGES flops each, with equal delay for all four.
REQ-015 SHALL detect a rising edge on a pin as synchronized value 1 with a one-flop-delayed value of 0.
REQ-016 SHALL, with the srclk edge first sampled high at edge N and SYNC_STAGES=2, update the shift register at edge N+2 as {shift[WIDTH-2:0], ser_sync}.
REQ-017 SHALL, on an rclk rising edge, copy the shift register to storage at edge N+2 and assert latch_valid for the cycle after edge N+2.
REQ-018 SHALL, on a simultaneous srclk and rclk edge, latch the pre-shift value into storage and also perform the shift.
REQ-019 SHALL register parallel_out as storage when synchronized oe=0 and all-zero when oe=1, updated one cycle after storage.
REQ-020 SHALL drive cascade_out combinationally from shift[WIDTH-1].
REQ-021 SHALL implement the FSM IDLE (count 0), SHIFTING (0<count<WIDTH), FULL (count==WIDTH) and OVER (count>WIDTH).
REQ-022 SHALL move the FSM on each shift to the state matching the new count, with count saturating at 2*WIDTH and the FSM remaining in OVER.
REQ-023 SHALL, on a latch, set frame_error to 1 unless the state is FULL, hold frame_error until the next latch, and return to IDLE (or SHIFTING with count 1 if a shift coincides).
REQ-024 SHALL ignore srclk and rclk falling edges, and SHALL NOT shift on a level that is held.
REQ-025 SHALL rely on drivers to hold each pin level for at least SYNC_STAGES+1 clocks; shorter pulses are unsupported.

Reset
REQ-026 SHALL, on reset, clear the shift register, storage, parallel_out, latch_valid, frame_error and bit_count to 0, set the FSM to IDLE, and load the synchronizers with ser=0, srclk=0, rclk=0 and oe=1.
REQ-027 SHALL, on reset mid-frame, discard the partial frame; a pin already high when reset releases SHALL NOT produce an edge.

Structure
REQ-028 SHALL place the FSM state enum and a default-width constant in the shared package hc595_rx_pkg.
REQ-029 SHALL implement the synchronizer plus rise detection as sub-module sync_edge_detect, instantiated once per pin (oe uses only the level).

Verification
REQ-030 SHALL cover this scenario: shift 8 bits of 0xA5 MSB first, then pulse rclk, with oe=0 -> parallel_out=0xA5, one latch_valid pulse, frame_error=0, bit_count returns to 0.
REQ-031 SHALL cover this scenario: shift 5 bits then latch -> frame_error=1 and storage=the previous storage shifted left by 5 with the new bits; shift 12 bits then latch -> frame_error=1 and the state passes through OVER.
REQ-032 SHALL cover this scenario: storage=0x3C with oe toggled to 1 -> parallel_out=0x00; oe back to 0 -> 0x3C, with the 3-cycle latency checked.
REQ-033 SHALL cover this scenario: the eighth srclk rise coincides with the rclk rise -> storage=the 7-bit pre-shift value and bit_count=1 afterwards.
REQ-034 SHALL cover this scenario: reset asserted after 4 shifts while srclk is held high -> all outputs 0 and no spurious shift after release.
REQ-035 SHALL cover this scenario: two chained instances with cascade_out feeding ser, shifting 16 bits of 0x12AB -> downstream=0x12 and upstream=0xAB.
